mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU (port 0) and loader/DMA (port 1) share one memory, one access per 3 cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter (
    input  logic       clk,
    input  logic       rst_,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_rd,
    output logic       mem_wr,
    input  logic [7:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic       win;
    logic       we_r;
    logic [4:0] addr_r;
    logic [7:0] wdata_r;
    logic [7:0] rdata_r;
    logic       pick;
    logic       start;

    assign start = (state == IDLE) && (req0 || req1);

`ifdef MEM_ARB_RR_EN
    // last holds the most recently granted port; reset value 1 makes port 0 preferred first
    logic last;

    always_comb begin
        pick = req1;
        if (req0 && req1) pick = ~last;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)      last <= 1'b1;
        else if (start) last <= pick;
    end
`else
    always_comb begin
        pick = req1 & ~req0;
    end
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            win     <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCESS;
                        win     <= pick;
                        we_r    <= pick ? we1 : we0;
                        addr_r  <= pick ? addr1 : addr0;
                        wdata_r <= pick ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (!we_r) rdata_r <= mem_rdata;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only, so an asynchronous reset clears them at once
    always_comb begin
        busy      = (state == ACCESS) || (state == DONE);
        gnt0      = busy && !win;
        gnt1      = busy && win;
        ack0      = (state == DONE) && !win;
        ack1      = (state == DONE) && win;
        mem_rd    = (state == ACCESS) && !we_r;
        mem_wr    = (state == ACCESS) && we_r;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        rdata     = rdata_r;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timing reference model plus directed and random scenarios.
module tb_mem_arbiter;

    logic       clk;
    logic       rst_;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1, busy, mem_rd, mem_wr;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mem_arbiter dut (
        .clk(clk), .rst_(rst_),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the arbiter: asynchronous read, write on the clock edge
    logic [7:0] ram [32];
    always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    logic [27:0] dut_vec;
    assign dut_vec = {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, busy, mem_addr, mem_wdata, rdata};

    // Reference model: a transaction sampled in cycle `start` strobes memory in start+1 and acks in start+2
    logic [7:0] ref_mem [32];
    int         cyc;
    int         start;
    bit         m_win, m_we, m_last;
    logic [4:0] m_addr;
    logic [7:0] m_wdata, m_rdata;

    task automatic model_reset();
        start   = -10;
        m_win   = 1'b0;
        m_we    = 1'b0;
        m_last  = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
    endtask

    task automatic model_edge();
        bit w;
        if (cyc == start + 1) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_mem[m_addr];
        end
        if (cyc >= start + 3 && (req0 || req1)) begin
`ifdef MEM_ARB_RR_EN
            w = (req0 && req1) ? !m_last : req1;
`else
            w = !req0;
`endif
            start   = cyc;
            m_win   = w;
            m_last  = w;
            m_we    = w ? we1 : we0;
            m_addr  = w ? addr1 : addr0;
            m_wdata = w ? wdata1 : wdata0;
        end
        cyc++;
    endtask

    function automatic logic [27:0] exp_vec();
        bit acc, dn, bz;
        acc = (cyc == start + 1);
        dn  = (cyc == start + 2);
        bz  = acc || dn;
        return {bz && !m_win, bz && m_win, dn && !m_win, dn && m_win,
                acc && !m_we, acc && m_we, bz, m_addr, m_wdata, m_rdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_) model_edge();
        else      cyc++;
        #1;
    endtask

    task automatic do_reset();
        #2 rst_ = 1'b0;
        model_reset();
        tick();
        #2 rst_ = 1'b1;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if (dut_vec !== '0) $display("FAIL reset_async got=%h exp=0", dut_vec); else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (dut_vec !== '0) $display("FAIL reset_held got=%h exp=0", dut_vec); else pass_cnt++;
        #2 rst_ = 1'b1;
        tick();
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec()); else pass_cnt++;
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h0A; wdata0 = 8'h5C;
        tick();
        req0 = 1'b0;
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL wr_access cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        chk_cnt++;
        if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 5'h0A, 8'h5C})
            $display("FAIL wr_strobe got=%b%b/%h/%h exp=10/0a/5c", mem_wr, mem_rd, mem_addr, mem_wdata);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({ack0, gnt0} !== 2'b11) $display("FAIL wr_ack got=%b%b exp=11", ack0, gnt0); else pass_cnt++;
        tick();
        req0 = 1'b1; we0 = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            req0 = 1'b0;
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rd_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (t == 1) begin
                chk_cnt++;
                if ({ack0, rdata} !== {1'b1, 8'h5C}) $display("FAIL rd_data got=%b/%h exp=1/5c", ack0, rdata); else pass_cnt++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] seq;
        int n;
        do_reset();
        seq = '0; n = 0;
        req0 = 1'b1; req1 = 1'b1;
        we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr0 = 5'($urandom); addr1 = 5'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL simul_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (ack0 || ack1) begin
                seq = {seq[2:0], ack1};
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk_cnt++;
        if (n != 4) $display("FAIL simul_count got=%0d exp=4", n); else pass_cnt++;
        chk_cnt++;
`ifdef MEM_ARB_RR_EN
        if (seq !== 4'b0101) $display("FAIL simul_order got=%b exp=0101", seq); else pass_cnt++;
`else
        if (seq !== 4'b0000) $display("FAIL simul_order got=%b exp=0000", seq); else pass_cnt++;
`endif
        tick();
        tick();
    endtask

    task automatic test_late_request();
        bit both, g1;
        both = 1'b0; g1 = 1'b0;
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom); wdata0 = 8'($urandom);
        tick();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = 5'($urandom);
        for (int t = 1; t <= 6; t++) begin
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL late_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (gnt0 && gnt1) both = 1'b1;
            if (t == 4) begin
                g1   = gnt1;
                req1 = 1'b0;
            end
            tick();
        end
        chk_cnt++;
        if (g1 !== 1'b1) $display("FAIL late_gnt1 got=%b exp=1", g1); else pass_cnt++;
        chk_cnt++;
        if (both) $display("FAIL late_mutex got=1 exp=0"); else pass_cnt++;
    endtask

    task automatic test_early_drop();
        int acks, strobes;
        acks = 0; strobes = 0;
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom); wdata0 = 8'($urandom);
        tick();
        req0 = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL drop_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (ack0) acks++;
            if (mem_rd || mem_wr) strobes++;
            tick();
        end
        chk_cnt++;
        if (acks != 1) $display("FAIL drop_acks got=%0d exp=1", acks); else pass_cnt++;
        chk_cnt++;
        if (strobes != 1) $display("FAIL drop_strobes got=%0d exp=1", strobes); else pass_cnt++;
    endtask

    task automatic test_reset_in_access();
        logic [7:0] orig;
        orig = ref_mem[31];
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h1F; wdata0 = ~orig;
        tick();
        req0 = 1'b0;
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL rst_acc_vec got=%h exp=%h", dut_vec, exp_vec()); else pass_cnt++;
        #2 rst_ = 1'b0;
        model_reset();
        #1;
        chk_cnt++;
        if (dut_vec !== '0) $display("FAIL rst_acc_clear got=%h exp=0", dut_vec); else pass_cnt++;
        tick();
        #2 rst_ = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rst_acc_after cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h1F;
        tick();
        req0 = 1'b0;
        tick();
        chk_cnt++;
        if ({ack0, rdata} !== {1'b1, orig}) $display("FAIL rst_acc_nowrite got=%b/%h exp=1/%h", ack0, rdata, orig); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int last_ack, nack;
        last_ack = -1; nack = 0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd0;
        for (int t = 0; t <= 12; t++) begin
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (ack1) begin
                if (last_ack >= 0) begin
                    chk_cnt++;
                    if (t - last_ack != 3) $display("FAIL b2b_spacing got=%0d exp=3", t - last_ack); else pass_cnt++;
                end
                chk_cnt++;
                if (rdata !== ref_mem[nack]) $display("FAIL b2b_rdata addr=%0d got=%h exp=%h", nack, rdata, ref_mem[nack]); else pass_cnt++;
                last_ack = t;
                nack++;
            end
            if (t % 3 == 0 && t > 0 && t < 12) addr1 = 5'(t / 3);
            if (t == 10) req1 = 1'b0;
            tick();
        end
        chk_cnt++;
        if (nack != 4) $display("FAIL b2b_count got=%0d exp=4", nack); else pass_cnt++;
    endtask

    task automatic test_random();
        bit both;
        both = 1'b0;
        for (int t = 0; t < 400; t++) begin
            req0   = ($urandom_range(0, 2) == 0);
            req1   = ($urandom_range(0, 2) == 0);
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            addr0  = 5'($urandom);
            addr1  = 5'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            tick();
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rand_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); else pass_cnt++;
            if (gnt0 && gnt1) both = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk_cnt++;
        if (both) $display("FAIL rand_mutex got=1 exp=0"); else pass_cnt++;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_ = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cyc = 0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        #1;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_late_request();
        test_early_drop();
        test_reset_in_access();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
